host_cmd_seq: RTL and testbench

- Synthesizable host-side command sequencer, directly upstream of DSO_dig's UART receive path.
- Takes a 24-bit command word, serializes it MSB-first as three bytes through an external UART transmitter (tx_data/trmt/tx_done handshake), then collects the response bytes from an external UART receiver.
- Response length is decided by opcode: 1 byte for normal commands, DUMP_BYTES for DUMP_CH.
- Replaces the bench-only send task so that FPGA self-test and regression benches drive DSO_dig through real logic.

---
 rtl/host_cmd_seq.sv | 193 +++++++++++++++++++
 tb/tb_host_cmd_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_seq.sv
// Host-side command sequencer: sends a 24-bit command as three UART bytes (MSB first),
// then collects the opcode-dependent number of response bytes from the UART receiver.
module host_cmd_seq #(
    parameter int unsigned DUMP_BYTES = 510,
    parameter int unsigned TIMEOUT    = 1048576,
    parameter logic [7:0]  ACK        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] cmd,
    input  logic        send_cmd,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [7:0]  resp,
    output logic        resp_vld,
    output logic        resp_last,
    output logic        cmd_sent,
    output logic        done,
    output logic        nak_err,
    output logic        timeout_err
);

    localparam int unsigned RXW = $clog2(DUMP_BYTES + 1);
    localparam int unsigned TOW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TOW-1:0] TO_LIMIT = TOW'(TIMEOUT - 2);
    localparam logic [7:0] OP_DUMP  = 8'h01;
    localparam logic [7:0] OP_RD_A  = 8'h07;
    localparam logic [7:0] OP_RD_B  = 8'h09;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TX_WAIT,
        S_RX_WAIT,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [23:0]    shadow_q;
    logic [1:0]     idx_q;
    logic [RXW-1:0] rx_cnt_q;
    logic [RXW-1:0] exp_cnt_q;
    logic           wr_class_q;
    logic [TOW-1:0] to_cnt_q;
    logic [7:0]     tx_data_q;
    logic           trmt_q;
    logic           clr_q;
    logic [7:0]     resp_q;
    logic           resp_vld_q;
    logic           resp_last_q;
    logic           cmd_sent_q;
    logic           done_q;
    logic           nak_q;
    logic           to_err_q;

    logic [7:0]     byte_sel_d;
    logic           rx_take_d;
    logic           rx_last_d;
    logic           to_hit_d;
    logic           is_dump_d;
    logic           wr_class_d;

    always_comb begin
        byte_sel_d = shadow_q[7:0];
        case (idx_q)
            2'd0:    byte_sel_d = shadow_q[23:16];
            2'd1:    byte_sel_d = shadow_q[15:8];
            default: byte_sel_d = shadow_q[7:0];
        endcase
        // rx_rdy seen while clr_rx_rdy is out is the same byte still pending its clear
        rx_take_d  = rx_rdy && !clr_q;
        rx_last_d  = (RXW'(rx_cnt_q + RXW'(1)) == exp_cnt_q);
        to_hit_d   = (to_cnt_q == TO_LIMIT);
        is_dump_d  = (cmd[23:16] == OP_DUMP);
        wr_class_d = !(is_dump_d || cmd[23:16] == OP_RD_A || cmd[23:16] == OP_RD_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            rx_cnt_q    <= '0;
            exp_cnt_q   <= '0;
            wr_class_q  <= 1'b0;
            to_cnt_q    <= '0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            clr_q       <= 1'b0;
            resp_q      <= '0;
            resp_vld_q  <= 1'b0;
            resp_last_q <= 1'b0;
            cmd_sent_q  <= 1'b0;
            done_q      <= 1'b0;
            nak_q       <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            clr_q       <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_last_q <= 1'b0;
            cmd_sent_q  <= 1'b0;
            done_q      <= 1'b0;

            // Bytes arriving outside the receive window are discarded
            if (rx_take_d && state_q != S_RX_WAIT) begin
                clr_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (send_cmd) begin
                        shadow_q   <= cmd;
                        nak_q      <= 1'b0;
                        to_err_q   <= 1'b0;
                        idx_q      <= '0;
                        rx_cnt_q   <= '0;
                        exp_cnt_q  <= is_dump_d ? RXW'(DUMP_BYTES) : RXW'(1);
                        wr_class_q <= wr_class_d;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_data_q <= byte_sel_d;
                    trmt_q    <= 1'b1;
                    to_cnt_q  <= '0;
                    state_q   <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_done) begin
                        to_cnt_q <= '0;
                        if (idx_q != 2'd2) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_LOAD;
                        end else begin
                            cmd_sent_q <= 1'b1;
                            state_q    <= S_RX_WAIT;
                        end
                    end else if (to_hit_d) begin
                        to_err_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
                end
                S_RX_WAIT: begin
                    if (rx_take_d) begin
                        clr_q      <= 1'b1;
                        resp_q     <= rx_data;
                        resp_vld_q <= 1'b1;
                        rx_cnt_q   <= rx_cnt_q + RXW'(1);
                        to_cnt_q   <= '0;
                        if (rx_last_d) begin
                            resp_last_q <= 1'b1;
                            if (wr_class_q && rx_data != ACK) begin
                                nak_q <= 1'b1;
                            end
                            state_q <= S_DONE;
                        end
                    end else if (to_hit_d) begin
                        to_err_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TOW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign tx_data     = tx_data_q;
    assign trmt        = trmt_q;
    assign clr_rx_rdy  = clr_q;
    assign resp        = resp_q;
    assign resp_vld    = resp_vld_q;
    assign resp_last   = resp_last_q;
    assign cmd_sent    = cmd_sent_q;
    assign done        = done_q;
    assign nak_err     = nak_q;
    assign timeout_err = to_err_q;

endmodule

// File: tb/tb_host_cmd_seq.sv
// Scoreboard bench for host_cmd_seq: directed commands against simple UART tx/rx models.
module tb_host_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] cmd;
    logic        send_cmd;
    logic        busy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  resp;
    logic        resp_vld;
    logic        resp_last;
    logic        cmd_sent;
    logic        done;
    logic        nak_err;
    logic        timeout_err;

    host_cmd_seq #(.DUMP_BYTES(510), .TIMEOUT(64), .ACK(8'hA5)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .send_cmd(send_cmd), .busy(busy),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .resp(resp), .resp_vld(resp_vld), .resp_last(resp_last),
        .cmd_sent(cmd_sent), .done(done), .nak_err(nak_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_trmt = 0;
    int n_cmd_sent = 0;
    int n_done = 0;
    int last_trmt_cyc = 0;
    int last_done_cyc = 0;
    int tx_seen = 0;
    int withhold_at = 0;
    bit done_pending = 0;

    logic [7:0] exp_tx[$];
    logic [8:0] exp_resp[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (done_pending) begin
                chk("done_after_last", {31'd0, done}, 32'd1);
                done_pending = 0;
            end
            if (trmt) begin
                n_trmt++;
                last_trmt_cyc = cyc;
                if (exp_tx.size() == 0) chk("unexpected_trmt", {24'd0, tx_data}, 32'hFFFF);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            if (resp_vld) begin
                if (exp_resp.size() == 0) chk("unexpected_resp_vld", {24'd0, resp}, 32'hFFFF);
                else begin
                    e = exp_resp.pop_front();
                    chk("resp", {24'd0, resp}, {24'd0, e[7:0]});
                    chk("resp_last", {31'd0, resp_last}, {31'd0, e[8]});
                end
                if (resp_last) done_pending = 1;
            end else if (resp_last) begin
                chk("resp_last_without_vld", 32'd1, 32'd0);
            end
            if (cmd_sent) n_cmd_sent++;
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
            end
        end
    end

    // UART transmitter model: tx_done three cycles after each strobe unless withheld
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt && !rst) begin
                tx_seen++;
                if (tx_seen != withhold_at) begin
                    repeat (3) @(negedge clk);
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Receiver model: hold rx_rdy until cleared, one extra cycle to exercise the guard
    task automatic rx_send(input logic [7:0] b);
        bit ok = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) begin
                ok = 1;
                break;
            end
        end
        chk("clr_rx_rdy_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic wait_for(input string name, input int sel, input int target, input int budget);
        bit hit = 0;
        int cur;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            cur = (sel == 0) ? n_trmt : (sel == 1) ? n_cmd_sent : n_done;
            if (cur >= target) hit = 1;
        end
        if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (!busy) hit = 1;
        end
        if (!hit) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [23:0] c, input int nbytes);
        wait_idle();
        if (nbytes > 0) exp_tx.push_back(c[23:16]);
        if (nbytes > 1) exp_tx.push_back(c[15:8]);
        if (nbytes > 2) exp_tx.push_back(c[7:0]);
        cmd      = c;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
    endtask

    // Full single-response transaction with final status checks
    task automatic txn(input string name, input logic [23:0] c, input logic [7:0] r,
                       input logic exp_nak);
        int cs0 = n_cmd_sent;
        int d0  = n_done;
        send(c, 3);
        wait_for({name, "_cmd_sent"}, 1, cs0 + 1, 100);
        exp_resp.push_back({1'b1, r});
        rx_send(r);
        wait_for({name, "_done"}, 2, d0 + 1, 100);
        repeat (3) @(negedge clk);
        chk({name, "_nak_err"}, {31'd0, nak_err}, {31'd0, exp_nak});
        chk({name, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_cmd_sent_cnt"}, n_cmd_sent, cs0 + 1);
        chk({name, "_done_cnt"}, n_done, d0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, d0, cs0;
        rst = 1'b1; cmd = '0; send_cmd = 1'b0; rx_data = '0; rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_trmt", {31'd0, trmt}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_resp", {24'd0, resp}, 32'd0);
        chk("rst_resp_vld", {31'd0, resp_vld}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_nak_err", {31'd0, nak_err}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write with ACK; a send_cmd during TX_WAIT must not disturb the byte stream
        t0 = n_trmt; cs0 = n_cmd_sent; d0 = n_done;
        send(24'h08_2A_BB, 3);
        wait_for("wr_first_trmt", 0, t0 + 1, 20);
        cmd = 24'h07_00_00;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        chk("busy_in_tx", {31'd0, busy}, 32'd1);
        wait_for("wr_cmd_sent", 1, cs0 + 1, 100);
        chk("wr_trmt_cnt", n_trmt - t0, 3);
        exp_resp.push_back({1'b1, 8'hA5});
        rx_send(8'hA5);
        wait_for("wr_done", 2, d0 + 1, 100);
        repeat (3) @(negedge clk);
        chk("wr_nak_err", {31'd0, nak_err}, 32'd0);
        chk("wr_cmd_sent_cnt", n_cmd_sent, cs0 + 1);
        chk("wr_done_cnt", n_done, d0 + 1);

        // NAK on write-class, then next send clears it
        txn("nak", 24'h03_FF_80, 8'h00, 1'b1);
        send(24'h09_2A_FF, 3);
        chk("nak_cleared_on_send", {31'd0, nak_err}, 32'd0);
        cs0 = n_cmd_sent; d0 = n_done;
        wait_for("rd_cmd_sent", 1, cs0 + 1, 100);
        exp_resp.push_back({1'b1, 8'hBB});
        rx_send(8'hBB);
        wait_for("rd_done", 2, d0 + 1, 100);
        repeat (3) @(negedge clk);
        chk("rd_nak_err", {31'd0, nak_err}, 32'd0);

        // Undefined opcode behaves as write-class
        txn("undef_op", 24'hFE_00_00, 8'h5A, 1'b1);

        // Dump: 510 incrementing bytes
        cs0 = n_cmd_sent; d0 = n_done;
        send(24'h01_00_FF, 3);
        wait_for("dump_cmd_sent", 1, cs0 + 1, 100);
        for (int i = 0; i < 510; i++) begin
            logic [8:0] v;
            v = 9'(i);
            exp_resp.push_back({(i == 509), v[7:0]});
            rx_send(v[7:0]);
        end
        wait_for("dump_done", 2, d0 + 1, 100);
        repeat (3) @(negedge clk);
        chk("dump_done_cnt", n_done, d0 + 1);
        chk("dump_busy", {31'd0, busy}, 32'd0);
        chk("dump_nak_err", {31'd0, nak_err}, 32'd0);

        // Stray byte in IDLE: cleared, response untouched
        rx_send(8'h5A);
        repeat (2) @(negedge clk);
        chk("stray_resp_kept", {24'd0, resp}, 32'h0000_00FD);

        // Timeout with tx_done withheld after the second byte
        t0 = n_trmt; cs0 = n_cmd_sent; d0 = n_done;
        withhold_at = tx_seen + 2;
        send(24'h04_12_34, 2);
        wait_for("to_done", 2, d0 + 1, 300);
        chk("to_timeout_err", {31'd0, timeout_err}, 32'd1);
        chk("to_trmt_cnt", n_trmt - t0, 2);
        chk("to_latency", last_done_cyc - last_trmt_cyc, 64);
        chk("to_no_cmd_sent", n_cmd_sent, cs0);
        repeat (2) @(negedge clk);
        chk("to_busy", {31'd0, busy}, 32'd0);

        // Reset between byte 2 and byte 3
        t0 = n_trmt;
        send(24'h02_11_22, 2);
        wait_for("rst_mid_trmt", 0, t0 + 2, 50);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_trmt", {31'd0, trmt}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_trmt_total", n_trmt - t0, 2);

        txn("recover", 24'h05_00_01, 8'hA5, 1'b0);

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("resp_queue_empty", exp_resp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
